// File: rtl/sincos_table_loader_if.sv
// Sine/cosine pair stream between the upstream producer and the table loader.
interface sincos_table_loader_if #(
  parameter int DATA_W = 32
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_sin;
  logic [DATA_W-1:0] s_cos;

  modport master (output s_valid, output s_sin, output s_cos, input s_ready);
  modport slave  (input s_valid, input s_sin, input s_cos, output s_ready);
endinterface

// File: rtl/sincos_table_loader.sv
// Loads DEPTH (sine, cosine) pairs into the dual-port table and releases the read port only once full.
// Optional CHECKSUM_EN adds a running sum of all accepted words on output checksum.
module sincos_table_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  sincos_table_loader_if.slave stream,
  output logic                 csb0,
  output logic                 web0,
  output logic [3:0]           wmask0,
  output logic [ADDR_W-1:0]    addr0,
  output logic [DATA_W-1:0]    din00,
  output logic [DATA_W-1:0]    din01,
  output logic                 csb1,
  output logic                 busy,
  output logic                 done,
  output logic                 err
`ifdef CHECKSUM_EN
  , output logic [DATA_W-1:0]  checksum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic [ADDR_W-1:0] count_r;
  logic              hs_s;

  assign hs_s = stream.s_valid & stream.s_ready;

  // Load sequencer; every output is a register so the table sees glitch-free controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      count_r        <= {ADDR_W{1'b0}};
      csb0           <= 1'b1;
      web0           <= 1'b1;
      wmask0         <= 4'h0;
      addr0          <= {ADDR_W{1'b0}};
      din00          <= {DATA_W{1'b0}};
      din01          <= {DATA_W{1'b0}};
      csb1           <= 1'b1;
      stream.s_ready <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef CHECKSUM_EN
      checksum       <= {DATA_W{1'b0}};
`endif
    end else begin
      // Write strobes last exactly one cycle unless a new handshake re-arms them.
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= 4'h0;
      err    <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r        <= ST_LOAD;
            count_r        <= {ADDR_W{1'b0}};
            stream.s_ready <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            csb1           <= 1'b1;
`ifdef CHECKSUM_EN
            checksum       <= {DATA_W{1'b0}};
`endif
          end else begin
            stream.s_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            err <= 1'b1;
          end else begin
            err <= 1'b0;
          end
          if (hs_s) begin
            csb0    <= 1'b0;
            web0    <= 1'b0;
            wmask0  <= 4'hF;
            addr0   <= count_r;
            din00   <= stream.s_sin;
            din01   <= stream.s_cos;
            count_r <= count_r + ADDR_W'(1);
`ifdef CHECKSUM_EN
            checksum <= checksum + stream.s_sin + stream.s_cos;
`endif
            // Counter wraps to zero here; leaving LOAD prevents any aliased second pass.
            if (count_r == LAST_ADDR) begin
              state_r        <= ST_LAST;
              stream.s_ready <= 1'b0;
            end else begin
              state_r        <= ST_LOAD;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_LAST: begin
          if (start) begin
            err <= 1'b1;
          end else begin
            err <= 1'b0;
          end
          state_r        <= ST_DONE;
          stream.s_ready <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b1;
          csb1           <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          stream.s_ready <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b0;
          csb1           <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_table_loader.sv
// Randomized self-checking bench: a queue of expected table writes is built from accepted pairs.
module tb_sincos_table_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sin;
    logic [DATA_W-1:0] cos;
    int                cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              csb0, web0, csb1, busy, done, err;
  logic [3:0]        wmask0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din00, din01;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                first_acc = 0;
  int                last_acc = 0;
  bit                mon_en = 1'b0;
  logic [DATA_W-1:0] sum_model = '0;
  wr_t               exp_q[$];

  sincos_table_loader_if #(.DATA_W(DATA_W)) stream ();

  sincos_table_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stream(stream.slave),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din00(din00), .din01(din01), .csb1(csb1), .busy(busy), .done(done), .err(err)
`ifdef CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted pair must appear on the write port exactly one cycle later, nothing else.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t w;
      checks++;
      if (csb0 === 1'b0) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d addr0=%0d required no write", cyc, addr0);
        end else begin
          w = exp_q.pop_front();
          if (w.cyc != cyc || addr0 !== w.addr || din00 !== w.sin || din01 !== w.cos ||
              wmask0 !== 4'hF || web0 !== 1'b0 || csb1 !== 1'b1) begin
            failures++;
            $display("FAIL write_port cyc=%0d got addr=%0d sin=%h cos=%h mask=%h web=%b csb1=%b required cyc=%0d addr=%0d sin=%h cos=%h mask=f web=0 csb1=1",
                     cyc, addr0, din00, din01, wmask0, web0, csb1, w.cyc, w.addr, w.sin, w.cos);
          end
        end
      end else begin
        if (web0 !== 1'b1 || wmask0 !== 4'h0) begin
          failures++;
          $display("FAIL idle_port cyc=%0d web0=%b wmask0=%h required web0=1 wmask0=0", cyc, web0, wmask0);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          w = exp_q.pop_front();
          failures++;
          $display("FAIL missing_write cyc=%0d csb0=%b required write addr=%0d", cyc, csb0, w.addr);
        end
      end
    end
  end

  // Called at a negedge while idle/done; a same-cycle s_valid must not be accepted.
  task automatic pulse_start();
    start = 1'b1;
    stream.s_valid = 1'b1;
    stream.s_sin = $urandom;
    stream.s_cos = $urandom;
    @(negedge clk);
    start = 1'b0;
    stream.s_valid = 1'b0;
    sum_model = '0;
    checks++;
    if (busy !== 1'b1 || stream.s_ready !== 1'b1 || csb1 !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL start_accept busy=%b ready=%b csb1=%b done=%b err=%b required 1 1 1 0 0",
               busy, stream.s_ready, csb1, done, err);
    end
`ifdef CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      failures++;
      $display("FAIL checksum_clear got=%0d required=0", checksum);
    end
`endif
  endtask

  // mode 0: b2b sin=i cos=~i; 1: 1-on/2-off random; 2: random valid+data; 3: sin=i cos=2i.
  task automatic send_load(input int mode, input int start_at, input int abort_at);
    int                n = 0;
    int                phase = 0;
    int                budget = 4000;
    bit                err_exp = 1'b0;
    bit                pulsed = 1'b0;
    bit                v;
    logic [DATA_W-1:0] si, co;
    wr_t               w;
    while (n < DEPTH && budget > 0) begin
      checks++;
      if (err !== err_exp) begin
        failures++;
        $display("FAIL err_pulse n=%0d got=%b required=%b", n, err, err_exp);
      end
      err_exp = 1'b0;
      if (n == abort_at) begin
        #1 reset = 1'b0;
        #1;
        checks++;
        if (csb0 !== 1'b1 || web0 !== 1'b1 || wmask0 !== 4'h0 || addr0 !== '0 || din00 !== '0 ||
            din01 !== '0 || csb1 !== 1'b1 || stream.s_ready !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
          failures++;
          $display("FAIL abort_reset csb0=%b web0=%b mask=%h addr=%0d d0=%h d1=%h csb1=%b rdy=%b busy=%b done=%b err=%b required reset values",
                   csb0, web0, wmask0, addr0, din00, din01, csb1, stream.s_ready, busy, done, err);
        end
        exp_q.delete();
        stream.s_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      case (mode)
        0: begin v = 1'b1; si = DATA_W'(n); co = ~DATA_W'(n); end
        1: begin v = (phase % 3 == 0); si = $urandom; co = $urandom; end
        3: begin v = 1'b1; si = DATA_W'(n); co = DATA_W'(2 * n); end
        default: begin v = ($urandom_range(1, 0) == 1); si = $urandom; co = $urandom; end
      endcase
      stream.s_valid = v;
      stream.s_sin = si;
      stream.s_cos = co;
      start = 1'b0;
      if (n == start_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
        err_exp = 1'b1;
      end
      if (v && stream.s_ready === 1'b1) begin
        w.addr = ADDR_W'(n);
        w.sin = si;
        w.cos = co;
        w.cyc = cyc + 1;
        exp_q.push_back(w);
        sum_model = sum_model + si + co;
        if (n == 0) first_acc = cyc + 1;
        last_acc = cyc + 1;
        n++;
      end
      phase++;
      budget--;
      @(negedge clk);
    end
    stream.s_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL load_timeout accepted=%0d required=%0d", n, DEPTH);
      return;
    end
    if (busy !== 1'b1 || csb1 !== 1'b1 || done !== 1'b0 || stream.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL last_cycle busy=%b csb1=%b done=%b ready=%b required 1 1 0 0",
               busy, csb1, done, stream.s_ready);
    end
    @(negedge clk);
    checks++;
    if (cyc != last_acc + 1 || csb1 !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || stream.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL table_release cyc=%0d csb1=%b done=%b busy=%b ready=%b required cyc=%0d 0 1 0 0",
               cyc, csb1, done, busy, stream.s_ready, last_acc + 1);
    end
`ifdef CHECKSUM_EN
    checks++;
    if (checksum !== sum_model) begin
      failures++;
      $display("FAIL checksum_done got=%0d required=%0d", checksum, sum_model);
    end
`endif
    // s_valid in DONE must not write; the monitor flags any write here.
    repeat (3) begin
      stream.s_valid = 1'b1;
      stream.s_sin = $urandom;
      stream.s_cos = $urandom;
      @(negedge clk);
    end
    stream.s_valid = 1'b0;
    checks++;
    if (csb1 !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL done_hold csb1=%b done=%b required 0 1", csb1, done);
    end
  endtask

  task automatic test_reset();
    stream.s_valid = 1'b0;
    stream.s_sin = '0;
    stream.s_cos = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (csb0 !== 1'b1 || web0 !== 1'b1 || wmask0 !== 4'h0 || addr0 !== '0 || din00 !== '0 ||
        din01 !== '0 || csb1 !== 1'b1 || stream.s_ready !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values csb0=%b web0=%b mask=%h addr=%0d csb1=%b rdy=%b busy=%b done=%b err=%b required reset values",
               csb0, web0, wmask0, addr0, csb1, stream.s_ready, busy, done, err);
    end
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_load(0, -1, -1);
    checks++;
    if (last_acc - first_acc != DEPTH - 1) begin
      failures++;
      $display("FAIL b2b_throughput span=%0d required=%0d", last_acc - first_acc, DEPTH - 1);
    end
  endtask

  task automatic test_bubbles();
    pulse_start();
    send_load(1, -1, -1);
    checks++;
    if (last_acc - first_acc != 3 * (DEPTH - 1)) begin
      failures++;
      $display("FAIL bubble_span span=%0d required=%0d", last_acc - first_acc, 3 * (DEPTH - 1));
    end
  endtask

  task automatic test_start_during_load();
    pulse_start();
    send_load(2, 50, -1);
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_load(1, -1, 100);
    pulse_start();
    send_load(2, -1, -1);
  endtask

  task automatic test_restart_from_done();
    pulse_start();
    send_load(0, -1, -1);
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_load(3, -1, -1);
    checks++;
    if (checksum !== DATA_W'(97920)) begin
      failures++;
      $display("FAIL checksum_known got=%0d required=97920", checksum);
    end
    pulse_start();
    send_load(2, -1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_start_during_load();
    test_reset_mid_load();
    test_restart_from_done();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_writes got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sincos_table_loader.md
Name: sincos_table_loader

Overview:
- Upstream stage of the phase-accumulator / sine-cosine lookup block.
- Accepts a stream of (sine, cosine) word pairs over a valid/ready handshake.
- Writes the pairs into the dual-port table through its write port (csb0/web0/wmask0/addr0/din00/din01).
- Releases the table read port (csb1) to the accumulator stage only after all DEPTH entries are written, so the lookup never reads a partially loaded table.

Parameters:
- ADDR_W, 8, table address width.
- DEPTH, 256, number of entries; must equal 2**ADDR_W.
- DATA_W, 32, width of each sine/cosine word.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle load request.
- s_valid  input  1  input pair valid.
- s_ready  output  1  loader can accept a pair this cycle.
- s_sin  input  DATA_W  sine word.
- s_cos  input  DATA_W  cosine word.
- csb0  output  1  table write-port select, active-low.
- web0  output  1  table write enable, active-low.
- wmask0  output  4  byte write mask.
- addr0  output  ADDR_W  table write address.
- din00  output  DATA_W  sine data to table.
- din01  output  DATA_W  cosine data to table.
- csb1  output  1  table read-port select to accumulator stage, active-low; 0 = table valid.
- busy  output  1  load in progress.
- done  output  1  table fully loaded.
- err  output  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset values: csb0=1, web0=1, wmask0=0, addr0=0, din00=0, din01=0, csb1=1, s_ready=0, busy=0, done=0, err=0. Reset also clears the state to IDLE and the entry counter to 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, LAST, DONE.
- IDLE: s_ready=0, csb1=1.
  - start=1 -> LOAD; counter=0.
- LOAD: busy=1, s_ready=1, csb1=1.
  - Handshake = s_valid & s_ready.
  - Each handshake at edge k produces one write cycle at k+1: csb0=0, web0=0, wmask0=4'hF, addr0=counter, din00=s_sin, din01=s_cos.
  - In all other cycles: csb0=1, web0=1, wmask0=0; addr0/din hold their last values.
  - Counter increments per handshake.
  - Throughput is one pair per cycle. Bubbles on s_valid insert idle cycles only; addresses stay contiguous.
  - Handshake with counter==DEPTH-1 -> LAST. The counter wraps to 0 and does not alias.
- LAST: one cycle; the final write is on the port. s_ready=0, busy=1, csb1=1. Unconditionally -> DONE.
- DONE: done=1, busy=0, csb1=0, s_ready=0.
  - csb1 first goes low 2 cycles after the last handshake.
  - start=1 -> LOAD; csb1=1 and done=0 from the next cycle; counter=0.
- start while in LOAD or LAST: ignored; err=1 for exactly one cycle; load continues unaffected.
- s_valid outside LOAD: no effect, no write.
- start and s_valid in the same cycle in IDLE/DONE: only the start is taken; the pair is not accepted (s_ready was 0).
- Reset mid-load: immediate return to reset values. The table is treated as invalid (csb1=1) until a complete new load finishes.
- Loader never drives a write while csb1=0.

Optional Feature:
- Macro CHECKSUM_EN.
- When defined, adds output checksum (DATA_W).
  - Running sum modulo 2**DATA_W of s_sin + s_cos over all accepted pairs.
  - Cleared to 0 on reset and on each accepted start.
  - Final value is stable from the first DONE cycle.
- When undefined, the port and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset, start, 256 back-to-back pairs (s_sin=i, s_cos=~i) -> 256 consecutive write cycles addr0=0..255 with matching data, wmask0=F. csb1 falls and done rises 2 cycles after handshake 255. busy low in DONE.
- s_valid driven in a 1-on/2-off pattern -> csb0 low only the cycle after each accepted pair, addr0 contiguous 0..255, no duplicate or skipped writes.
- start pulsed at entry 50 during LOAD -> err high exactly 1 cycle. Writes continue at addr 51 onward. done after 256 total entries.
- reset asserted (0) at entry 100 -> all outputs at reset values at once, csb1=1. A new start reloads from addr0=0.
- Second start from DONE -> csb1=1 and done=0 the next cycle. Full reload completes, csb1 returns to 0.
- CHECKSUM_EN build with s_sin=i, s_cos=2*i for i=0..255 -> checksum=97920 in DONE. Cleared to 0 after the next start.
